// File: rtl/vga_scaled_linebuf.sv
// vga_scaled_linebuf: VGA timing generator with a ping-pong line buffer.
// Source rows arrive over a valid/ready stream, and each source pixel is
// replicated SCALE x SCALE and centred in the active area. The rest of the
// active area is filled with BORDER. Sync, de and RGB share a 2-cycle pipeline.
module vga_scaled_linebuf #(
  parameter int                 H_ACTIVE = 640,
  parameter int                 H_FP     = 16,
  parameter int                 H_SYNC   = 96,
  parameter int                 H_BP     = 48,
  parameter int                 V_ACTIVE = 480,
  parameter int                 V_FP     = 10,
  parameter int                 V_SYNC   = 2,
  parameter int                 V_BP     = 33,
  parameter int                 SRC_W    = 256,
  parameter int                 SRC_H    = 240,
  parameter int                 SCALE    = 2,
  parameter int                 COLOR_W  = 12,
  parameter logic               HS_POL   = 1'b0,
  parameter logic               VS_POL   = 1'b0,
  parameter logic [COLOR_W-1:0] BORDER   = 12'hFFF
) (
  input  logic                   CLOCK_24,
  input  logic                   reset,
  input  logic [COLOR_W-1:0]     pix_data,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic                   frame_start,
  output logic                   underrun,
  input  logic                   underrun_clr,
  output logic [COLOR_W/3-1:0]   VGA_R,
  output logic [COLOR_W/3-1:0]   VGA_G,
  output logic [COLOR_W/3-1:0]   VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_IMG   = SRC_W * SCALE;
  localparam int V_IMG   = SRC_H * SCALE;
  localparam int H_OFF   = (H_ACTIVE - H_IMG) / 2;
  localparam int V_OFF   = (V_ACTIVE - V_IMG) / 2;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int RW      = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CW      = COLOR_W / 3;
  localparam int AW      = XW + 1;

  localparam logic [HW-1:0] H_LAST_C   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_OFF_C    = HW'(H_OFF);
  localparam logic [HW-1:0] H_END_C    = HW'(H_OFF + H_IMG);
  localparam logic [HW-1:0] HS_BEG_C   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST_C   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_OFF_C    = VW'(V_OFF);
  localparam logic [VW-1:0] V_END_C    = VW'(V_OFF + V_IMG);
  localparam logic [VW-1:0] VS_BEG_C   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SW-1:0] SUB_LAST_C = SW'(SCALE - 1);
  localparam logic [XW-1:0] COL_LAST_C = XW'(SRC_W - 1);
  localparam logic [RW-1:0] ROW_LAST_C = RW'(SRC_H - 1);

  // The scaled image must fit inside the active area.
  if (SRC_W * SCALE > H_ACTIVE) begin : g_bad_width
    $error("vga_scaled_linebuf: SRC_W*SCALE exceeds H_ACTIVE");
  end
  if (SRC_H * SCALE > V_ACTIVE) begin : g_bad_height
    $error("vga_scaled_linebuf: SRC_H*SCALE exceeds V_ACTIVE");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } wr_state_t;

  // Timing state
  logic [HW-1:0]      h_cnt_r, h_nxt_s;
  logic [VW-1:0]      v_cnt_r, v_nxt_s;
  logic               h_last_s, v_last_s;
  logic [SW-1:0]      h_sub_r, v_sub_r;
  logic [XW-1:0]      x_col_r;
  logic               h_win_r, v_win_r;
  logic               frame_start_r;
  logic               swap_s;

  // Writer state
  wr_state_t          state_r, state_n;
  logic [RW-1:0]      wr_row_r, row_n;
  logic [XW-1:0]      wr_col_r, col_n;
  logic               wr_sel_r, wr_sel_n;
  logic               rd_sel_r, rd_sel_n;
  logic               wr_en_s;
  logic               underrun_r, underrun_set_s;

  // Buffer and pipeline
  logic [COLOR_W-1:0] mem_r [0:(2**AW)-1];
  logic [AW-1:0]      wr_addr_s, rd_addr_s;
  logic [COLOR_W-1:0] rd_data_r;
  logic               act1_r, win1_r, hs1_r, vs1_r;
  logic               de_r, hs_r, vs_r;
  logic [COLOR_W-1:0] rgb_r;

  // Next counter position; there is no extra cycle at the wrap.
  always_comb begin
    h_last_s = (h_cnt_r == H_LAST_C);
    v_last_s = (v_cnt_r == V_LAST_C);
    if (h_last_s) begin
      h_nxt_s = '0;
      if (v_last_s) begin
        v_nxt_s = '0;
      end else begin
        v_nxt_s = v_cnt_r + VW'(1);
      end
    end else begin
      h_nxt_s = h_cnt_r + HW'(1);
      v_nxt_s = v_cnt_r;
    end
  end

  // Raster counters, sub-pixel/sub-line replication counters and window flags.
  always_ff @(posedge CLOCK_24 or posedge reset) begin
    if (reset) begin
      h_cnt_r       <= '0;
      v_cnt_r       <= '0;
      h_sub_r       <= '0;
      v_sub_r       <= '0;
      x_col_r       <= '0;
      h_win_r       <= (H_OFF == 0);
      v_win_r       <= (V_OFF == 0);
      frame_start_r <= 1'b0;
    end else begin
      h_cnt_r       <= h_nxt_s;
      v_cnt_r       <= v_nxt_s;
      frame_start_r <= (h_nxt_s == '0) && (v_nxt_s == V_ACT_C);
      // Column walk: restart at the left image edge, advance every SCALE pixels.
      if (h_nxt_s == H_OFF_C) begin
        h_sub_r <= '0;
        x_col_r <= '0;
      end else if (h_sub_r == SUB_LAST_C) begin
        h_sub_r <= '0;
        x_col_r <= x_col_r + XW'(1);
      end else begin
        h_sub_r <= h_sub_r + SW'(1);
      end
      // Line phase within a source row, realigned at the top image edge.
      if (h_last_s) begin
        if ((v_nxt_s == V_OFF_C) || (v_sub_r == SUB_LAST_C)) begin
          v_sub_r <= '0;
        end else begin
          v_sub_r <= v_sub_r + SW'(1);
        end
      end
      if (h_nxt_s == H_OFF_C) begin
        h_win_r <= 1'b1;
      end else if (h_nxt_s == H_END_C) begin
        h_win_r <= 1'b0;
      end
      if (v_nxt_s == V_OFF_C) begin
        v_win_r <= 1'b1;
      end else if (v_nxt_s == V_END_C) begin
        v_win_r <= 1'b0;
      end
    end
  end

  // A swap happens at the start of the first output line of every source row.
  assign swap_s = (h_cnt_r == '0) && v_win_r && (v_sub_r == '0);

  // Ready only while filling; a swap or frame restart takes the cycle instead.
  assign pix_ready = (state_r == ST_FILL) && !swap_s && !frame_start_r;

  assign underrun_set_s = swap_s && (state_r != ST_FULL);

  // Writer next-state: frame restart, then row swap, then pixel acceptance.
  always_comb begin
    state_n  = state_r;
    row_n    = wr_row_r;
    col_n    = wr_col_r;
    wr_sel_n = wr_sel_r;
    rd_sel_n = rd_sel_r;
    wr_en_s  = 1'b0;
    if (frame_start_r) begin
      row_n   = '0;
      col_n   = '0;
      state_n = ST_FILL;
    end else if (swap_s) begin
      rd_sel_n = wr_sel_r;
      wr_sel_n = ~wr_sel_r;
      if (wr_row_r == ROW_LAST_C) begin
        state_n = ST_IDLE;
      end else begin
        row_n   = wr_row_r + RW'(1);
        col_n   = '0;
        state_n = ST_FILL;
      end
    end else begin
      case (state_r)
        ST_FILL: begin
          if (pix_valid) begin
            wr_en_s = 1'b1;
            col_n   = wr_col_r + XW'(1);
            if (wr_col_r == COL_LAST_C) begin
              state_n = ST_FULL;
            end else begin
              state_n = ST_FILL;
            end
          end else begin
            state_n = ST_FILL;
          end
        end
        ST_IDLE: state_n = ST_IDLE;
        ST_FULL: state_n = ST_FULL;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Writer registers and the sticky underrun flag (set beats clear).
  always_ff @(posedge CLOCK_24 or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wr_row_r   <= '0;
      wr_col_r   <= '0;
      wr_sel_r   <= 1'b1;
      rd_sel_r   <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      wr_row_r <= row_n;
      wr_col_r <= col_n;
      wr_sel_r <= wr_sel_n;
      rd_sel_r <= rd_sel_n;
      if (underrun_set_s) begin
        underrun_r <= 1'b1;
      end else if (underrun_clr) begin
        underrun_r <= 1'b0;
      end
    end
  end

  // The read side follows the swap in the same cycle so h=0 sees the new row.
  assign wr_addr_s = {wr_sel_r, wr_col_r};
  assign rd_addr_s = {(swap_s ? wr_sel_r : rd_sel_r), x_col_r};

  // Ping-pong line buffer with registered read; contents need no reset.
  always_ff @(posedge CLOCK_24) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= pix_data;
    end
    rd_data_r <= mem_r[rd_addr_s];
  end

  // Two-stage output pipeline keeping sync, de and colour aligned.
  always_ff @(posedge CLOCK_24 or posedge reset) begin
    if (reset) begin
      act1_r <= 1'b0;
      win1_r <= 1'b0;
      hs1_r  <= 1'b0;
      vs1_r  <= 1'b0;
      de_r   <= 1'b0;
      hs_r   <= ~HS_POL;
      vs_r   <= ~VS_POL;
      rgb_r  <= '0;
    end else begin
      act1_r <= (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
      win1_r <= h_win_r && v_win_r;
      hs1_r  <= (h_cnt_r >= HS_BEG_C) && (h_cnt_r < HS_END_C);
      vs1_r  <= (v_cnt_r >= VS_BEG_C) && (v_cnt_r < VS_END_C);
      de_r   <= act1_r;
      hs_r   <= hs1_r ? HS_POL : ~HS_POL;
      vs_r   <= vs1_r ? VS_POL : ~VS_POL;
      if (!act1_r) begin
        rgb_r <= '0;
      end else if (win1_r) begin
        rgb_r <= rd_data_r;
      end else begin
        rgb_r <= BORDER;
      end
    end
  end

  assign frame_start = frame_start_r;
  assign underrun    = underrun_r;
  assign de          = de_r;
  assign VGA_HS      = hs_r;
  assign VGA_VS      = vs_r;
  assign VGA_R       = rgb_r[COLOR_W-1 -: CW];
  assign VGA_G       = rgb_r[2*CW-1 -: CW];
  assign VGA_B       = rgb_r[CW-1:0];

endmodule

// File: tb/tb_vga_scaled_linebuf.sv
// Directed bench for vga_scaled_linebuf using a reduced raster so whole
// frames fit in a short run: 56x27 total, 40x20 active, 16x8 source, x2.
// Image origin is (4,2); source pixel (row,col) carries {row,4'h0,col}.
module tb_vga_scaled_linebuf;

  localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 20, VFP = 2, VSY = 2, VBP = 3;
  localparam int SW = 16, SH = 8, SC = 2;
  localparam int TH = 56, TV = 27, FRAME = 1512;
  localparam int HOFF = 4, HEND = 36, VOFF = 2, VEND = 18;
  localparam int UR_LINE = 12;
  localparam logic [11:0] BORDER_C = 12'hA5C;

  logic        CLOCK_24 = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_start;
  logic        underrun;
  logic        underrun_clr = 1'b0;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, de;

  int checks = 0;
  int errors = 0;
  int pos_h, pos_v;
  int src_row = 0, src_col = 0;
  bit src_en = 1'b0, src_rand = 1'b0, src_arm = 1'b0, src_hold = 1'b0;

  vga_scaled_linebuf #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SRC_W(SW), .SRC_H(SH), .SCALE(SC), .COLOR_W(12),
    .HS_POL(1'b0), .VS_POL(1'b0), .BORDER(BORDER_C)
  ) dut (
    .CLOCK_24(CLOCK_24), .reset(reset),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .frame_start(frame_start), .underrun(underrun), .underrun_clr(underrun_clr),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .de(de)
  );

  always #5 CLOCK_24 = ~CLOCK_24;

  // Raster position the DUT counters hold right now; outputs lag it by 2.
  always_ff @(posedge CLOCK_24 or posedge reset) begin
    if (reset) begin
      pos_h <= 0;
      pos_v <= 0;
    end else if (pos_h == TH - 1) begin
      pos_h <= 0;
      pos_v <= (pos_v == TV - 1) ? 0 : pos_v + 1;
    end else begin
      pos_h <= pos_h + 1;
    end
  end

  // Pixel source: presents beats at the falling edge, tracks acceptance.
  initial begin
    pix_valid = 1'b0;
    pix_data  = 12'h000;
    forever begin
      @(negedge CLOCK_24);
      if (frame_start) begin
        src_row = 0;
        src_col = 0;
      end
      if (src_hold && pos_h == 0 && pos_v == UR_LINE) begin
        src_hold = 1'b0;
        src_arm  = 1'b0;
        src_row  = 6;
        src_col  = 0;
      end
      if (src_arm && src_row == 5 && src_col == 10) src_hold = 1'b1;
      pix_valid = src_en && !reset && !src_hold &&
                  (src_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      pix_data  = {src_row[3:0], 4'h0, src_col[3:0]};
      if (pix_valid && pix_ready) begin
        if (src_col == SW - 1) begin
          src_col = 0;
          src_row = src_row + 1;
        end else begin
          src_col = src_col + 1;
        end
      end
    end
  end

  function automatic logic [12:0] exp_px(input int h, input int v, input bit stale);
    int row, col;
    logic [3:0] r4, c4;
    if (h >= HA || v >= VA) return 13'h0000;
    if (h >= HOFF && h < HEND && v >= VOFF && v < VEND) begin
      row = (v - VOFF) / SC;
      col = (h - HOFF) / SC;
      if (stale && row == 5 && col >= 10) row = 3;
      r4 = row[3:0];
      c4 = col[3:0];
      return {1'b1, r4, 4'h0, c4};
    end
    return {1'b1, BORDER_C};
  endfunction

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    @(negedge CLOCK_24);
    while (!(pos_h == h && pos_v == v) && n < 2 * FRAME) begin
      @(negedge CLOCK_24);
      n++;
    end
    if (!(pos_h == h && pos_v == v)) begin
      errors++;
      $display("FAIL wait_pos timeout target (%0d,%0d)", h, v);
    end
  endtask

  task automatic wait_frame_start();
    int n;
    n = 0;
    @(negedge CLOCK_24);
    while (frame_start !== 1'b1 && n < 2 * FRAME) begin
      @(negedge CLOCK_24);
      n++;
    end
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_timeout got %b required 1", frame_start);
    end
  endtask

  // Compare de+RGB over the active width plus two blanking pixels of line v.
  task automatic check_line(input int v, input bit stale);
    logic [12:0] got, expv;
    wait_pos(2, v);
    for (int h = 0; h < HA + 2; h++) begin
      got  = {de, VGA_R, VGA_G, VGA_B};
      expv = exp_px(h, v, stale);
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL pixel line %0d h %0d got %h required %h", v, h, got, expv);
      end
      @(negedge CLOCK_24);
    end
  endtask

  task automatic test_reset();
    int k;
    repeat (3) @(negedge CLOCK_24);
    reset = 1'b0;
    repeat (30) @(negedge CLOCK_24);
    checks++;
    if ({de, VGA_R, VGA_G, VGA_B} !== {1'b1, BORDER_C}) begin
      errors++;
      $display("FAIL pre_reset_border got %h required %h", {de, VGA_R, VGA_G, VGA_B}, {1'b1, BORDER_C});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({de, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, pix_ready, frame_start, underrun} !== 19'b0_000000000000_11_000) begin
      errors++;
      $display("FAIL reset_outputs got %b required %b",
               {de, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, pix_ready, frame_start, underrun}, 19'b0_000000000000_11_000);
    end
    @(negedge CLOCK_24);
    reset = 1'b0;
    k = 0;
    do begin
      @(negedge CLOCK_24);
      k++;
    end while (VGA_HS === 1'b1 && k < 200);
    checks++;
    if (k != HA + HFP + 2) begin
      errors++;
      $display("FAIL first_hs_edge got %0d required %0d", k, HA + HFP + 2);
    end
    checks++;
    if (VGA_VS !== 1'b1) begin
      errors++;
      $display("FAIL vs_idle_line0 got %b required 1", VGA_VS);
    end
  endtask

  task automatic test_frame_start();
    wait_frame_start();
    checks++;
    if (pos_h != 0 || pos_v != VA) begin
      errors++;
      $display("FAIL frame_start_pos got (%0d,%0d) required (0,%0d)", pos_h, pos_v, VA);
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_first_frame got %b required 1", underrun);
    end
    src_en = 1'b1;
    underrun_clr = 1'b1;
    @(negedge CLOCK_24);
    underrun_clr = 1'b0;
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL pix_ready_after_fs got %b required 1", pix_ready);
    end
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL frame_start_width got %b required 0", frame_start);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clr got %b required 0", underrun);
    end
  endtask

  task automatic test_scaling();
    check_line(0, 1'b0);
    check_line(2, 1'b0);
    check_line(3, 1'b0);
    check_line(17, 1'b0);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_scaling got %b required 0", underrun);
    end
  endtask

  task automatic test_sync();
    int hs_n, vs_n, de_n, fs_n;
    hs_n = 0; vs_n = 0; de_n = 0; fs_n = 0;
    wait_pos(0, 0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (VGA_HS === 1'b0) hs_n++;
      if (VGA_VS === 1'b0) vs_n++;
      if (de === 1'b1) de_n++;
      if (frame_start === 1'b1) fs_n++;
      @(negedge CLOCK_24);
    end
    checks++;
    if (hs_n != 2 * TV * HSY) begin
      errors++;
      $display("FAIL hs_count got %0d required %0d", hs_n, 2 * TV * HSY);
    end
    checks++;
    if (vs_n != 2 * VSY * TH) begin
      errors++;
      $display("FAIL vs_count got %0d required %0d", vs_n, 2 * VSY * TH);
    end
    checks++;
    if (de_n != 2 * VA * HA) begin
      errors++;
      $display("FAIL de_count got %0d required %0d", de_n, 2 * VA * HA);
    end
    checks++;
    if (fs_n != 2) begin
      errors++;
      $display("FAIL frame_start_count got %0d required 2", fs_n);
    end
    wait_pos(1, VA + VFP);
    checks++;
    if (VGA_VS !== 1'b1) begin
      errors++;
      $display("FAIL vs_before_edge got %b required 1", VGA_VS);
    end
    @(negedge CLOCK_24);
    checks++;
    if (VGA_VS !== 1'b0) begin
      errors++;
      $display("FAIL vs_edge got %b required 0", VGA_VS);
    end
  endtask

  task automatic test_backpressure();
    src_rand = 1'b1;
    wait_frame_start();
    check_line(2, 1'b0);
    check_line(9, 1'b0);
    check_line(17, 1'b0);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_backpressure got %b required 0", underrun);
    end
    src_rand = 1'b0;
  endtask

  task automatic test_underrun();
    wait_frame_start();
    @(negedge CLOCK_24);
    src_arm = 1'b1;
    wait_pos(0, UR_LINE);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_before_swap got %b required 0", underrun);
    end
    underrun_clr = 1'b1;
    @(negedge CLOCK_24);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set_beats_clr got %b required 1", underrun);
    end
    check_line(UR_LINE, 1'b1);
    check_line(UR_LINE + 1, 1'b1);
    check_line(UR_LINE + 2, 1'b0);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky got %b required 1", underrun);
    end
    underrun_clr = 1'b1;
    @(negedge CLOCK_24);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_cleared got %b required 0", underrun);
    end
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_scaling();
    test_sync();
    test_backpressure();
    test_underrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scaled_linebuf.md
Name: vga_scaled_linebuf

Overview:
- Parametrised VGA timing generator with a ping-pong line buffer and an integer upscaler.
- Accepts source-resolution pixels (NES-style 256x240) over a valid/ready stream and replicates each one SCALE x SCALE.
- Centres the scaled image in the active area, fills the rest of the active area with a border colour, and drives sync and RGB.
- Sits between the tile/pixel renderer and the VGA pins. Replaces ad-hoc per-module timing counters.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SRC_W, 256, source pixels per row
SRC_H, 240, source rows per frame
SCALE, 2, integer replication factor, >=1
COLOR_W, 12, pixel width (4:4:4 RGB)
HS_POL, 0, active level of VGA_HS
VS_POL, 0, active level of VGA_VS
BORDER, 12'hFFF, colour shown in active area outside the image

Ports:
CLOCK_24  in  1  pixel clock, rising edge
reset  in  1  asynchronous, active-high
pix_data  in  COLOR_W  source pixel
pix_valid  in  1  pix_data valid
pix_ready  out  1  block accepts pix_data this cycle
frame_start  out  1  one-cycle pulse requesting row 0 of a new frame
underrun  out  1  sticky: a row was not complete at its swap point
underrun_clr  in  1  synchronous clear of underrun
VGA_R/VGA_G/VGA_B  out  COLOR_W/3 each  colour outputs
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
de  out  1  high during the active area

Behaviour:
- One clock; reset is asynchronous and active-high.
- Elaboration checks: SRC_W*SCALE<=H_ACTIVE and SRC_H*SCALE<=V_ACTIVE, otherwise $error.
- Derived values: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525); H_OFF=(H_ACTIVE-SRC_W*SCALE)/2 (64); V_OFF=(V_ACTIVE-SRC_H*SCALE)/2 (0).
- Counters: h_cnt wraps 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and itself wraps 0..V_TOTAL-1. There is no extra cycle at the wrap.
- Sync: HS is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. VS is active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Pixel sources:
  - de=1 inside the window (h_cnt in [H_OFF, H_OFF+SRC_W*SCALE), v_cnt in [V_OFF, V_OFF+SRC_H*SCALE)): RGB comes from buffer rd_sel at column x_src.
  - de=1 outside the window: RGB=BORDER.
  - Blanking: RGB=0.
- Column index: x_src comes from a sub-pixel counter (0..SCALE-1) plus a column counter. No divider.
- Pipeline latency: 2 cycles. The state for counter value (h,v) appears on RGB/HS/VS/de two clocks later, all aligned. The buffer read is registered.
- frame_start pulses for one cycle at h_cnt==0, v_cnt==V_ACTIVE (first blanking line).
- Writer FSM:
  - IDLE: pix_ready=0. On frame_start: wr_row=0, wr_col=0, go to FILL.
  - FILL: pix_ready=1. Each valid&ready writes buf[wr_sel][wr_col] and increments wr_col. Acceptance at wr_col==SRC_W-1 goes to FULL.
  - FULL: pix_ready=0.
- Swap event: occurs at h_cnt==0 on lines v_cnt==V_OFF+r*SCALE, r=0..SRC_H-1. On a swap event:
  - rd_sel<=wr_sel and wr_sel toggles.
  - If wr_row==SRC_H-1, go to IDLE. Otherwise wr_row++, wr_col=0, go to FILL.
- Underrun: a swap event while in FILL (or IDLE) sets underrun. The swap still occurs and unwritten columns show stale data. The partial fill is abandoned and the next row restarts at column 0.
- frame_start while not IDLE forces wr_row=0, wr_col=0, FILL.
- Simultaneous valid&ready and swap event: the swap wins and the beat is not accepted (pix_ready is forced low that cycle).
- underrun_clr and an underrun set in the same cycle: set wins.
- Reset values:
  - Counters 0, FSM IDLE, rd_sel=0, wr_sel=1, underrun=0, pix_ready=0, frame_start=0, de=0, RGB=0.
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL.
  - Buffer contents are undefined.
- Reset asserted mid-frame: all of the above takes effect immediately and timing restarts at (0,0).

Test Plan:
- Reset: assert reset mid-line -> RGB=0, de=0, HS/VS inactive, pix_ready=0 within the reset cycle. After release, first HS active edge at cycle 658 (656+2 latency).
- Sync timing: run 2 frames -> HS active 96 cycles per 800-cycle period; VS active 1600 cycles per 420000-cycle period; de high 640 cycles per line over 480 lines.
- Scaling: source delivers pixel value = column index with valid held high -> line 0 shows BORDER at h 0..63, values 0,0,1,1,...,255,255 at h 64..575, BORDER at 576..639. Lines 0 and 1 are identical.
- Backpressure: pix_valid toggled pseudo-randomly at 50% -> image is identical to the scaling case and underrun stays 0.
- Underrun: withhold valid after 100 pixels of row 5 -> underrun=1 from line 10. Row 5 shows columns 100..255 stale. Row 6 renders correctly. underrun_clr returns underrun to 0.
- frame_start: observe pulse exactly once per frame at v_cnt=480, h_cnt=0. pix_ready rises the next cycle.
